recon_arbiter: RTL and testbench

RECON_ARBITER -- requirements
Module: recon_arbiter

---
 rtl/recon_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/recon_arbiter.sv | 69 ++++++
 tb/tb_recon_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/recon_pkg.sv
// Shared operand type, width and evaluation function for the recon arbiter slice.
// Pure declarations: no latency, no flow control.
package recon_pkg;

  localparam int OPW = 5;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
  } recon_op_t;

  function automatic logic recon_eval(input recon_op_t op);
    logic w_ab;
    w_ab = op.a & op.b;
    return (~w_ab | op.d) & (~(w_ab ^ op.c) | op.e);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or above ptr, wrapping; combinational grant.
// Grant is gated by adv and reset; ptr moves past the winner only on an actual grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 adv,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  logic [IW-1:0] w_idx;
  int            w_j;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(r_ptr) + k) % N;
      if (!w_found && req[w_j[IW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_j[IW-1:0];
      end
    end
  end

  assign grant     = (w_found && adv && !rst) ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign grant_idx = w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (|grant) begin
      r_ptr <= (w_idx == IW'(N-1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/recon_arbiter.sv
// N_REQ requesters share a 2-stage evaluation pipeline (operand reg S1, result reg S2); latency 2.
// Both stages advance only when S2 is empty or being consumed; otherwise everything holds.
module recon_arbiter
  import recon_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [OPW*N_REQ-1:0]     req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     rsp_x,
  input  logic                     rsp_ready
);

  localparam int IW = $clog2(N_REQ);

  logic             w_adv;
  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_gidx;
  recon_op_t        w_op;

  logic             r_s1_v;
  logic [IW-1:0]    r_s1_id;
  recon_op_t        r_s1_op;
  logic             r_rsp_v;
  logic [IW-1:0]    r_rsp_id;
  logic             r_rsp_x;

  assign w_adv = ~r_rsp_v | rsp_ready;
  assign w_op  = recon_op_t'(req_data[w_gidx*OPW +: OPW]);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .adv       (w_adv),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_id  <= '0;
      r_s1_op  <= '0;
      r_rsp_v  <= 1'b0;
      r_rsp_id <= '0;
      r_rsp_x  <= 1'b0;
    end else if (w_adv) begin
      r_rsp_v  <= r_s1_v;
      r_rsp_id <= r_s1_id;
      // keep rsp_x quiet while no result is present
      r_rsp_x  <= r_s1_v & recon_eval(r_s1_op);
      r_s1_v   <= |w_grant;
      r_s1_id  <= w_gidx;
      r_s1_op  <= w_op;
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_v;
  assign rsp_id    = r_rsp_id;
  assign rsp_x     = r_rsp_x;

endmodule

// File: tb/tb_recon_arbiter.sv
// Directed bench for recon_arbiter: cycle model plus response scoreboard, and literal checks.
module tb_recon_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [5*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic           rsp_x;
  logic           rsp_ready = 1'b1;

  recon_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_x     (rsp_x),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit run     = 1'b0;

  typedef struct { int id; bit x; } rsp_t;
  rsp_t sb[$];
  int   acc_log[$];
  int   rid_log[$];
  bit   rx_log[$];

  // abstract model state: ring pointer and the two pipeline slots
  int m_ptr = 0;
  bit m_s1v = 1'b0, m_v = 1'b0;
  int m_s1id = 0, m_id = 0;
  bit m_s1x = 1'b0, m_x = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit spec_x(input logic [4:0] v);
    bit a, b, c, d, e, ab;
    {a, b, c, d, e} = v;
    ab = a && b;
    return (!ab || d) && ((ab == c) || e);
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    bit adv;
    logic [4:0] d;
    if (run) begin
      if (rst) begin
        m_ptr = 0; m_s1v = 0; m_v = 0; m_s1id = 0; m_id = 0; m_s1x = 0; m_x = 0;
        sb.delete();
      end else begin
        adv = !m_v || rsp_ready;
        w   = winner(req_valid, m_ptr);
        if (adv) begin
          m_v  = m_s1v;
          m_id = m_s1id;
          m_x  = m_s1x;
          m_s1v = (w >= 0);
          if (w >= 0) begin
            d      = req_data[w*5 +: 5];
            m_s1id = w;
            m_s1x  = spec_x(d);
            sb.push_back('{w, spec_x(d)});
            m_ptr  = (w + 1) % N;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int w;
    bit adv;
    int exp_rdy;
    rsp_t e;
    if (run) begin
      adv     = !m_v || rsp_ready;
      w       = winner(req_valid, m_ptr);
      exp_rdy = (!rst && adv && w >= 0) ? (1 << w) : 0;
      chk("req_ready", int'(req_ready), exp_rdy);
      chk("rsp_valid", int'(rsp_valid), int'(m_v));
      if (m_v) begin
        chk("rsp_id", int'(rsp_id), m_id);
        chk("rsp_x", int'(rsp_x), int'(m_x));
      end
      if (!rst && |(req_ready & req_valid)) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) acc_log.push_back(k);
      end
      if (!rst && rsp_valid && rsp_ready) begin
        rid_log.push_back(int'(rsp_id));
        rx_log.push_back(rsp_x);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: response id %0d with nothing outstanding (t=%0t)", rsp_id, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_id", int'(rsp_id), e.id);
          chk("sb_x", int'(rsp_x), int'(e.x));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    rid_log.delete();
    rx_log.delete();
  endtask

  initial begin
    run       = 1'b1;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    step();
    step();
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);

    // single request
    req_valid = '0;
    rst       = 1'b0;
    req_data[4:0] = 5'b11011;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", int'(req_ready), 1);
    step();
    req_valid = '0;
    chk("single_lat1", int'(rsp_valid), 0);
    step();
    chk("single_valid", int'(rsp_valid), 1);
    chk("single_id", int'(rsp_id), 0);
    chk("single_x", int'(rsp_x), 1);
    step();

    // fairness with all requesters valid
    do_reset();
    req_data = {5'b00100, 5'b11110, 5'b11001, 5'b11011};
    clear_logs();
    req_valid = 4'b1111;
    repeat (5) step();
    req_valid = '0;
    repeat (3) step();
    chk("fair_acc_n", acc_log.size(), 5);
    chk("fair_rid_n", rid_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("fair_acc", acc_log[i], i % 4);
      chk("fair_rid", rid_log[i], i % 4);
    end

    // pointer wrap
    do_reset();
    clear_logs();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1001;
    #1;
    chk("wrap_first", int'(req_ready), 8);
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (3) step();
    chk("wrap_n", acc_log.size(), 3);
    chk("wrap_0", acc_log[0], 1);
    chk("wrap_1", acc_log[1], 3);
    chk("wrap_2", acc_log[2], 0);

    // backpressure
    do_reset();
    clear_logs();
    req_valid = 4'b1111;
    step();
    step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", int'(req_ready), 0);
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_id", int'(rsp_id), 0);
      chk("bp_x", int'(rsp_x), 1);
      step();
    end
    chk("bp_hold_id", int'(rsp_id), 0);
    rsp_ready = 1'b1;
    step();
    step();
    req_valid = '0;
    repeat (4) step();
    chk("bp_rid_n", rid_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_rid", rid_log[i], i);

    // reset mid-operation
    do_reset();
    req_valid = 4'b1111;
    step();
    step();
    chk("mid_busy", int'(rsp_valid), 1);
    rst       = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    chk("mid_cleared", int'(rsp_valid), 0);
    step();
    step();
    chk("mid_no_stale", int'(rsp_valid), 0);
    req_valid = 4'b1111;
    #1;
    chk("mid_ptr0", int'(req_ready), 1);
    req_valid = '0;
    step();

    // exhaustive truth table through requester 1
    do_reset();
    clear_logs();
    req_valid = 4'b0010;
    for (int v = 0; v < 32; v++) begin
      req_data[9:5] = 5'(v);
      step();
    end
    req_valid = '0;
    repeat (3) step();
    chk("tt_n", rx_log.size(), 32);
    chk("tt_11001", int'(rx_log[25]), 0);
    chk("tt_11110", int'(rx_log[30]), 1);
    chk("tt_00100", int'(rx_log[4]), 0);
    chk("tt_11011", int'(rx_log[27]), 1);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
